crc_check: RTL and testbench

Receive-side CRC-5 checker, the counterpart of the team's serial CRC-5 generator. It accepts one codeword per valid/ready handshake: 4 data bits plus the 5-bit CRC the generator produced. It shifts all 9 bits serially through the same LFSR, LSB first, and reports whether the remainder (syndrome) is zero. It sits on the receive path between the link deserializer and the consumer of the 4-bit payload.

---
 rtl/crc_pkg.sv | 15 +
 rtl/crc5_lfsr_step.sv | 24 ++
 rtl/crc_check.sv | 111 +++++++++++
 tb/tb_crc_check.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/crc_pkg.sv
// Shared constants and FSM state type for the CRC-5 generator/checker pair.
package crc_pkg;

   localparam int unsigned      CRC_W      = 5;
   localparam int unsigned      DATA_W     = 4;
   localparam int unsigned      FRAME_BITS = DATA_W + CRC_W;
   localparam logic [CRC_W-1:0] CRC5_POLY  = 5'b00101;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      DONE
   } crc_chk_state_t;

endpackage

// File: rtl/crc5_lfsr_step.sv
// One serial step of the CRC-5 Galois LFSR; state is packed {s1..s5}, so s5 sits in bit 0.
module crc5_lfsr_step
   import crc_pkg::*;
(
   input  logic [CRC_W-1:0] state_i,
   input  logic             bit_i,
   input  logic [CRC_W-1:0] poly_i,
   output logic [CRC_W-1:0] state_o
);

   logic fb;

   assign fb = bit_i ^ state_i[0];

   // Stage 1 has no predecessor, so it is just the x^0 tap (always set for a CRC polynomial).
   always_comb begin
      state_o          = '0;
      state_o[CRC_W-1] = poly_i[0] & fb;
      for (int unsigned i = 1; i < CRC_W; i++) begin
         state_o[CRC_W-1-i] = state_i[CRC_W-i] ^ (poly_i[i] & fb);
      end
   end

endmodule

// File: rtl/crc_check.sv
// Receive-side CRC-5 checker: shifts data_in[0..3] then crc_in[0..4] through the LFSR and flags a nonzero syndrome.
// Define CRC_CHECK_ERRCNT_EN to add a saturating err_count output.
module crc_check
   import crc_pkg::*;
#(
   parameter logic [CRC_W-1:0] POLY = CRC5_POLY
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] data_in,
   input  logic [CRC_W-1:0]  crc_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] data_out,
   output logic              crc_err,
   output logic [CRC_W-1:0]  syndrome
`ifdef CRC_CHECK_ERRCNT_EN
   ,
   output logic [7:0]        err_count
`endif
);

   localparam logic [3:0] LAST_BIT = 4'(FRAME_BITS - 1);

   crc_chk_state_t        state_q, state_d;
   logic                  rdy_q;
   logic [FRAME_BITS-1:0] frame_q;
   logic [3:0]            cnt_q;
   logic [CRC_W-1:0]      lfsr_q, lfsr_d;
   logic                  crc_err_q;
   logic                  accept, last_bit, shift_bit;

   assign accept    = in_ready & in_valid;
   assign last_bit  = (state_q == SHIFT) && (cnt_q == LAST_BIT);
   assign shift_bit = frame_q[cnt_q];

   crc5_lfsr_step u_step (
      .state_i (lfsr_q),
      .bit_i   (shift_bit),
      .poly_i  (POLY),
      .state_o (lfsr_d)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (accept)    state_d = SHIFT;
         SHIFT:   if (last_bit)  state_d = DONE;
         DONE:    if (out_ready) state_d = IDLE;
         default:                state_d = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = rdy_q && (state_q == IDLE);
      out_valid = (state_q == DONE);
   end

   // rdy_q holds in_ready low while reset is asserted and releases it on the first edge after.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdy_q     <= 1'b0;
         frame_q   <= '0;
         cnt_q     <= '0;
         lfsr_q    <= '0;
         crc_err_q <= 1'b0;
      end else begin
         rdy_q <= 1'b1;
         if (accept) begin
            frame_q <= {crc_in, data_in};
            cnt_q   <= '0;
            lfsr_q  <= '0;
         end else if (state_q == SHIFT) begin
            lfsr_q <= lfsr_d;
            cnt_q  <= cnt_q + 4'd1;
            if (last_bit) begin
               crc_err_q <= |lfsr_d;
            end
         end
      end
   end

   assign data_out = frame_q[DATA_W-1:0];
   assign crc_err  = crc_err_q;
   assign syndrome = lfsr_q;

`ifdef CRC_CHECK_ERRCNT_EN
   logic [7:0] err_cnt_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_cnt_q <= '0;
      end else if (out_valid && out_ready && crc_err_q && (err_cnt_q != '1)) begin
         err_cnt_q <= err_cnt_q + 8'd1;
      end
   end

   assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_crc_check.sv
// Self-checking bench for crc_check: polynomial-division reference model plus directed and random codewords.
module tb_crc_check;

   localparam logic [4:0] POLY = 5'b00101;

   logic       clk = 1'b0;
   logic       reset;
   logic       in_valid = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] data_in = '0;
   logic [4:0] crc_in = '0;
   logic       in_ready, out_valid, crc_err;
   logic [3:0] data_out;
   logic [4:0] syndrome;
`ifdef CRC_CHECK_ERRCNT_EN
   logic [7:0] err_count;
`endif

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   crc_check #(.POLY(POLY)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .data_in   (data_in),
      .crc_in    (crc_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .data_out  (data_out),
      .crc_err   (crc_err),
      .syndrome  (syndrome)
`ifdef CRC_CHECK_ERRCNT_EN
      ,
      .err_count (err_count)
`endif
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic note_fail(input string name);
      tests++;
      fails++;
      $display("FAIL %s: wait bound expired at %0t", name, $time);
   endtask

   // Reference: remainder of (codeword(x) * x^5) mod P(x), first shifted bit = highest degree.
   function automatic logic [4:0] poly_rem(input logic [13:0] dvd);
      logic [13:0] r = dvd;
      logic [13:0] p = {8'd0, 1'b1, POLY};
      for (int k = 13; k >= 5; k--) begin
         if (r[k]) r = r ^ (p << (k - 5));
      end
      return r[4:0];
   endfunction

   // Remainder coefficient of x^k lives in stage s(k+1); outputs are packed {s1..s5}.
   function automatic logic [4:0] rev5(input logic [4:0] v);
      logic [4:0] o;
      for (int i = 0; i < 5; i++) o[i] = v[4-i];
      return o;
   endfunction

   function automatic logic [4:0] syn_of(input logic [3:0] d, input logic [4:0] c);
      logic [8:0]  seq = {c, d};
      logic [13:0] dvd = '0;
      for (int j = 0; j < 9; j++) dvd[13-j] = seq[j];
      return rev5(poly_rem(dvd));
   endfunction

   function automatic logic [4:0] gen_crc(input logic [3:0] d);
      logic [13:0] dvd = '0;
      for (int j = 0; j < 4; j++) dvd[8-j] = d[j];
      return rev5(poly_rem(dvd));
   endfunction

   // Transaction-level model checked every cycle.
   int unsigned m_phase = 0;
   int unsigned m_left = 0;
   logic        m_rdy = 1'b0;
   logic [3:0]  m_data = '0;
   logic [4:0]  m_syn = '0;
   logic [7:0]  m_errcnt = '0;

   always @(negedge clk) begin
      if (!reset) begin
         m_phase  = 0;
         m_rdy    = 1'b0;
         m_errcnt = '0;
         chk("rst_in_ready", in_ready, 0);
         chk("rst_out_valid", out_valid, 0);
         chk("rst_data_out", data_out, 0);
         chk("rst_crc_err", crc_err, 0);
         chk("rst_syndrome", syndrome, 0);
`ifdef CRC_CHECK_ERRCNT_EN
         chk("rst_err_count", err_count, 0);
`endif
      end else begin
         chk("in_ready", in_ready, m_rdy && (m_phase == 0));
         chk("out_valid", out_valid, m_phase == 2);
         if (m_phase == 2) begin
            chk("data_out", data_out, m_data);
            chk("syndrome", syndrome, m_syn);
            chk("crc_err", crc_err, m_syn != 0);
         end
`ifdef CRC_CHECK_ERRCNT_EN
         chk("err_count", err_count, m_errcnt);
`endif
         case (m_phase)
            0: if (m_rdy && in_valid) begin
               m_data  = data_in;
               m_syn   = syn_of(data_in, crc_in);
               m_left  = 9;
               m_phase = 1;
            end
            1: begin
               m_left--;
               if (m_left == 0) m_phase = 2;
            end
            default: if (out_ready) begin
               if (m_syn != 0 && m_errcnt != 8'd255) m_errcnt++;
               m_phase = 0;
            end
         endcase
         m_rdy = 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready();
      int unsigned n = 0;
      while (!in_ready && n < 40) begin
         tick();
         n++;
      end
      if (!in_ready) note_fail("in_ready_wait");
   endtask

   task automatic wait_valid(output logic ok);
      int unsigned n = 0;
      while (!out_valid && n < 30) begin
         tick();
         n++;
      end
      ok = out_valid;
      if (!ok) note_fail("out_valid_wait");
   endtask

   // exp_err: 0/1 = required crc_err, 2 = left to the model.
   task automatic xfer(input logic [3:0] d, input logic [4:0] c, input int unsigned stall,
                       input int exp_err, output logic [4:0] syn_seen);
      int unsigned lat = 0;
      syn_seen = 'x;
      wait_ready();
      in_valid  = 1'b1;
      data_in   = d;
      crc_in    = c;
      out_ready = (stall == 0);
      tick();
      in_valid = 1'b0;
      data_in  = 4'($urandom);
      crc_in   = 5'($urandom);
      while (!out_valid && lat < 30) begin
         tick();
         lat++;
      end
      if (!out_valid) begin
         note_fail("out_valid_wait");
         return;
      end
      chk("latency", lat + 1, 10);
      chk("payload", data_out, d);
      syn_seen = syndrome;
      if (exp_err != 2) chk("crc_err_expect", crc_err, exp_err[0]);
      if (stall != 0) begin
         repeat (stall) begin
            tick();
            chk("hold_valid", out_valid, 1);
            chk("hold_in_ready", in_ready, 0);
            chk("hold_data", data_out, d);
            chk("hold_syndrome", syndrome, syn_of(d, c));
         end
         out_ready = 1'b1;
      end
      tick();
      chk("in_ready_after_done", in_ready, 1);
      out_ready = 1'b0;
   endtask

   initial begin
      logic [4:0] s;
      logic [8:0] f;
      logic       ok;
      int         seen;

      chk("model_gen_0001", gen_crc(4'b0001), 5'b10110);
      chk("model_syn_flip", syn_of(4'b0001, 5'b10111), 5'b01011);
      chk("model_syn_zero", syn_of(4'b0000, 5'b00000), 5'b00000);

      reset = 1'b1;
      #1;
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("in_ready_after_reset", in_ready, 1);

      xfer(4'b0000, 5'b00000, 0, 0, s);
      chk("zero_syndrome", s, 5'b00000);
      xfer(4'b0001, 5'b10110, 0, 0, s);
      chk("good_syndrome", s, 5'b00000);
      xfer(4'b0001, 5'b10111, 0, 1, s);
      chk("bad_syndrome", s, 5'b01011);

      for (int d = 0; d < 16; d++) begin
         xfer(4'(d), gen_crc(4'(d)), 0, 0, s);
         for (int b = 0; b < 9; b++) begin
            f = {gen_crc(4'(d)), 4'(d)} ^ (9'd1 << b);
            xfer(f[3:0], f[8:4], 0, 1, s);
         end
      end

      // Backpressure with a codeword offered while the result is still held.
      wait_ready();
      in_valid = 1'b1;
      data_in  = 4'h9;
      crc_in   = gen_crc(4'h9);
      tick();
      in_valid = 1'b0;
      wait_valid(ok);
      repeat (5) begin
         tick();
         chk("bp_in_ready", in_ready, 0);
         chk("bp_out_valid", out_valid, 1);
         chk("bp_data", data_out, 4'h9);
      end
      in_valid = 1'b1;
      data_in  = 4'h6;
      crc_in   = gen_crc(4'h6) ^ 5'b00100;
      tick();
      chk("bp_ignored_in_ready", in_ready, 0);
      out_ready = 1'b1;
      tick();
      chk("bp_release_in_ready", in_ready, 1);
      out_ready = 1'b0;
      tick();
      in_valid = 1'b0;
      chk("bp_pending_accepted", in_ready, 0);
      wait_valid(ok);
      chk("bp_pending_data", data_out, 4'h6);
      chk("bp_pending_err", crc_err, 1);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      // Reset in the middle of the shift drops the codeword.
      wait_ready();
      in_valid = 1'b1;
      data_in  = 4'h5;
      crc_in   = gen_crc(4'h5) ^ 5'b10000;
      tick();
      in_valid = 1'b0;
      repeat (4) tick();
      reset = 1'b0;
      repeat (2) tick();
      reset = 1'b1;
      tick();
      chk("abort_in_ready", in_ready, 1);
      seen = 0;
      repeat (15) begin
         tick();
         if (out_valid) seen++;
      end
      chk("abort_no_output", seen, 0);
      xfer(4'hA, gen_crc(4'hA), 0, 0, s);
      chk("abort_next_syndrome", s, 5'b00000);

      for (int n = 0; n < 150; n++) begin
         logic [3:0] d;
         int unsigned mode;
         d    = 4'($urandom);
         mode = $urandom_range(0, 2);
         if (mode == 0) begin
            xfer(d, gen_crc(d), $urandom_range(0, 3), 0, s);
         end else if (mode == 1) begin
            f = {gen_crc(d), d} ^ (9'd1 << $urandom_range(0, 8));
            xfer(f[3:0], f[8:4], $urandom_range(0, 3), 1, s);
         end else begin
            xfer(d, 5'($urandom), $urandom_range(0, 3), 2, s);
         end
         repeat ($urandom_range(0, 2)) tick();
      end

`ifdef CRC_CHECK_ERRCNT_EN
      reset = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      repeat (3) xfer(4'h3, gen_crc(4'h3) ^ 5'b00001, 0, 1, s);
      xfer(4'h3, gen_crc(4'h3), 0, 0, s);
      chk("err_count_3", err_count, 3);
      repeat (260) xfer(4'hC, gen_crc(4'hC) ^ 5'b01000, 0, 1, s);
      chk("err_count_sat", err_count, 255);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      note_fail("global_timeout");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
